// File: rtl/rv_ifetch.sv
// rv_ifetch: RISC-V instruction fetch stage.
// Credit-limited in-order fetch into a small {pc, instr} buffer, with redirect flush and stale-response dropping.
module rv_ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] fifo_rd;
    logic [PTR_W-1:0] fifo_wr;
    logic [PTR_W-1:0] tag_rd;
    logic [PTR_W-1:0] tag_wr;
    fetch_entry_t     fifo_mem [FIFO_DEPTH];
    logic [31:0]      tag_mem  [FIFO_DEPTH];

    logic [31:0]      redirect_base;
    logic [SUM_W-1:0] credit_used;
    logic             req_fire;
    logic             deq;
    logic             rsp_keep;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    // Handshake and credit decode; a same-cycle decode pop frees its slot for a new request.
    always_comb begin
        redirect_base    = redirect_pc & 32'hFFFF_FFFC;
        head             = fifo_mem[fifo_rd];
        push_entry.pc    = tag_mem[tag_rd];
        push_entry.instr = imem_rsp_data;
        if_valid         = (fifo_count != '0) && !redirect_valid;
        deq              = if_valid && if_ready;
        credit_used      = SUM_W'(outstanding) + SUM_W'(fifo_count) - SUM_W'(deq);
        imem_req_valid   = rst_n && !redirect_valid && (credit_used < SUM_W'(FIFO_DEPTH));
        req_fire         = imem_req_valid && imem_req_ready;
        rsp_keep         = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    end

    assign imem_req_addr = fetch_pc;
    assign if_pc         = head.pc;
    assign if_instr      = head.instr;

    // Fetch PC: a redirect overrides the sequential advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_base;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // After a redirect every request still in flight is stale, including those of
    // earlier undrained redirects, so the drop count becomes what remains outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
            end else if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    // Tag FIFO: every response retires one tag, kept or dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr <= '0;
            tag_rd <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                tag_mem[tag_wr] <= fetch_pc;
                tag_wr          <= tag_wr + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                tag_rd <= tag_rd + PTR_W'(1);
            end
        end
    end

    // Instruction buffer; credit guarantees a free slot for every kept response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            fifo_rd    <= fifo_wr;
            fifo_count <= '0;
        end else begin
            if (rsp_keep) begin
                fifo_mem[fifo_wr] <= push_entry;
                fifo_wr           <= fifo_wr + PTR_W'(1);
            end
            if (deq) begin
                fifo_rd <= fifo_rd + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(rsp_keep) - CNT_W'(deq);
        end
    end

endmodule

// File: tb/tb_rv_ifetch.sv
// tb_rv_ifetch: directed and randomized checks of rv_ifetch against an architectural fetch-stream model.
// The bench models memory as an in-order latency queue and decode as the expected sequential PC stream.
module tb_rv_ifetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic        w_one = 1'b1;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;

    always #5 clk = ~clk;

    rv_ifetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
    );

    rv_ifetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(w_one),
        .imem_rsp_valid(w_zero), .imem_rsp_data(w_zero32),
        .redirect_valid(w_zero), .redirect_pc(w_zero32),
        .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_ready(w_one)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    mreq_t       mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          occ = 0;
    int          epoch = 0;
    int          last_due = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          first_req_cyc = -1;
    int          first_ifv_cyc = -1;
    int          n_if_hs = 0;
    logic [31:0] exp_if_pc = 32'h0;
    logic [31:0] exp_req_pc = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy, input logic mrdy);
        logic  rsp_now;
        logic  pop_exp;
        logic  keep;
        int    used;
        int    d;
        mreq_t e;
        @(negedge clk);
        rst_n          = 1'b1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        imem_req_ready = mrdy;
        rsp_now        = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(mq[0].addr) : $urandom;
        #1;
        pop_exp = (occ > 0) && !rv && rdy;
        used    = mq.size() + occ - (pop_exp ? 1 : 0);
        check("if_valid", 32'(if_valid), 32'((occ > 0) && !rv));
        check("req_valid", 32'(imem_req_valid), 32'(!rv && (used < DEPTH)));
        if (if_valid && first_ifv_cyc < 0) first_ifv_cyc = cyc;
        if (if_valid && if_ready) begin
            check("if_pc", if_pc, exp_if_pc);
            check("if_instr", if_instr, mem_word(exp_if_pc));
            exp_if_pc += 32'd4;
            n_if_hs++;
        end
        keep = 1'b0;
        if (rsp_now) begin
            e    = mq.pop_front();
            keep = !rv && (e.ep == epoch);
        end
        if (rv) begin
            epoch++;
            exp_if_pc  = rpc & 32'hFFFF_FFFC;
            exp_req_pc = rpc & 32'hFFFF_FFFC;
            occ        = 0;
        end else begin
            occ = occ + (keep ? 1 : 0) - (pop_exp ? 1 : 0);
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_req_pc);
            if (first_req_cyc < 0) first_req_cyc = cyc;
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (d < last_due) d = last_due;
            last_due = d;
            mq.push_back('{addr: imem_req_addr, due: d, ep: epoch});
            exp_req_pc += 32'd4;
        end
        cyc++;
    endtask

    task automatic wait_if(input string tag, input logic [31:0] pc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (if_valid) begin
                seen = 1'b1;
                check({tag, "_pc"}, if_pc, pc);
                check({tag, "_instr"}, if_instr, mem_word(pc));
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        int n0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
        check("rst_wrap_valid", 32'(w_req_valid), 32'd0);

        // Streaming with 1-cycle memory; the wrap instance is checked alongside.
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("wrap_req0", w_req_addr, 32'hFFFF_FFFC);
        check("wrap_valid0", 32'(w_req_valid), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap_req1", w_req_addr, 32'h0000_0000);
        check("wrap_valid1", 32'(w_req_valid), 32'd1);
        n0 = n_if_hs;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap_valid2", 32'(w_req_valid), 32'd0);
        check("first_latency", 32'(first_ifv_cyc - first_req_cyc), 32'd2);
        for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        check("throughput", 32'(n_if_hs - n0), 32'd10);

        // Decode stall: buffer fills to the credit limit and requests stop.
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_if_valid", 32'(if_valid), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Slow memory, redirect with two requests in flight.
        drain();
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        wait_if("redir_0x100", 32'h0000_0100);

        // Redirect landing in the same cycle as a response.
        drain();
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("redir_same_if_valid", 32'(if_valid), 32'd0);
        wait_if("redir_0x200", 32'h0000_0200);

        // Misaligned redirect target.
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_1003, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("align_req_valid", 32'(imem_req_valid), 32'd1);
        check("align_req_addr", imem_req_addr, 32'h0000_1000);
        wait_if("redir_0x1003", 32'h0000_1000);

        // Randomized traffic with varying latency, backpressure and redirects.
        for (int ph = 1; ph <= 4; ph++) begin
            lat_hi = ph;
            for (int i = 0; i < 700; i++) begin
                step(($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0, $urandom,
                     ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            end
        end
        check("progress", 32'(n_if_hs > 500), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
